ibex_rf_scrub_ctrl: RTL and testbench
=====================================

// Module: ibex_rf_scrub_ctrl
// PURPOSE
//  Write-port arbiter and zeroization sequencer for the index-renamed register file.
//  Shares the single RF write port between core writeback and a sweep engine that
//  zeroes architectural x1..x(NUM_WORDS-1), e.g. on a context switch.
//  Each zero write also clears the old physical copy and rotates the idle register.
//  After a sweep, no physical register holds pre-request data.
// PARAMETERS
//  RV32E      0   1: sweep x1..x15 (NUM_WORDS=16); 0: x1..x31 (NUM_WORDS=32)
//  DataWidth  32  write data width
//  MAX_DEFER  4   max consecutive cycles scrub yields to core (fair mode only; >=1)
// PORTS
//  clk_i         in   1          clock
//  rst_i         in   1          synchronous active-high reset
//  scrub_req_i   in   1          start sweep; sampled only in IDLE
//  scrub_busy_o  out  1          high in SWEEP
//  scrub_done_o  out  1          1-cycle pulse in DONE
//  wb_we_i       in   1          core writeback enable
//  wb_waddr_i    in   5          core writeback address
//  wb_wdata_i    in   DataWidth  core writeback data
//  wb_stall_o    out  1          core write not accepted this cycle; core holds request
//  rf_we_o       out  1          to RF we_a_i
//  rf_waddr_o    out  5          to RF waddr_a_i
//  rf_wdata_o    out  DataWidth  to RF wdata_a_i
// BEHAVIOUR
//  - Clock clk_i; reset rst_i is synchronous and active-high.
//  - Reset state: IDLE, ptr=1, skip='0, defer=0.
//  - Output values in reset: busy=0, done=0, stall=0, rf_we_o=wb_we_i (IDLE passthrough).
//  - FSM states:
//      IDLE: -> SWEEP when scrub_req_i=1.
//      SWEEP: -> DONE after the last register is written or skipped.
//      DONE: -> IDLE unconditionally.
//  - IDLE/DONE: core path is combinational passthrough; stall=0; zero latency.
//  - SWEEP, per cycle:
//      - want = !skip[ptr].
//      - If skip[ptr]=1: ptr advances; port stays free for core.
//      - Scrub grant: rf_we_o=1, rf_waddr_o=ptr, rf_wdata_o=0, ptr++.
//        Grant rule is set by the mode (see CONFIGURATION).
//      - An accepted core write to r!=0 sets skip[r].
//        Effect: a post-request value is never zeroed by a later slot.
//      - A core write to x0 passes through and sets no skip bit.
//      - Stalled core write: no RF effect, no skip update.
//  - Last register (ptr=NUM_WORDS-1) granted or skipped -> DONE; ptr=1, skip='0, defer=0.
//  - scrub_req_i is ignored in SWEEP and DONE; no restart, no queueing.
//  - Minimum sweep length: NUM_WORDS-1 cycles (31, or 15 with RV32E).
//  - Post-condition at DONE: every xN holds 0 or the last core value accepted in SWEEP.
//  - rst_i in mid-sweep: next cycle IDLE, busy=0, no done pulse; the partial sweep is
//    abandoned. The RF resets on its own reset.
//  - Width: ptr is 5b; defer is $clog2(MAX_DEFER+1) bits, saturating.
// CONFIGURATION
//  RF_SCRUB_FAIR_EN defined (fair mode):
//   - Core has priority in SWEEP.
//   - defer++ each cycle that want=1 and core took the port.
//   - When defer==MAX_DEFER, scrub is granted: stall=wb_we_i, defer=0.
//   - defer also resets on any scrub grant.
//  RF_SCRUB_FAIR_EN undefined (strict mode):
//   - Scrub has strict priority in SWEEP: stall=wb_we_i for the whole SWEEP.
//   - Skip bitmap stays 0; defer counter is not built.
// TESTING
//  1 Idle passthrough: wb_we_i=1, waddr=5, wdata=0xDEADBEEF -> same on rf_*, stall=0, busy=0.
//  2 Quiet sweep (RV32E=0): pulse scrub_req_i -> rf_we_o=1 for 31 cycles, waddr 1..31,
//    wdata=0; done pulses once; then all RF reads return 0.
//  3 Strict mode, wb_we_i held during SWEEP -> stall=1 every SWEEP cycle;
//    the write lands in the DONE cycle.
//  4 Fair mode, MAX_DEFER=4, wb_we_i held -> pattern is 4 core writes then 1 scrub write;
//    sweep completes; the last core value survives in its register.
//  5 Fair mode, core writes x20=0x1234 at ptr=3 -> x20 is skipped (no zero write);
//    after DONE, x20 reads 0x1234 and all other registers read 0.
//  6 rst_i at ptr=10 -> next cycle busy=0, no done pulse;
//    a new scrub_req_i restarts the sweep at x1.

Source files
------------

// File: rtl/ibex_rf_scrub_ctrl.sv
// ibex_rf_scrub_ctrl: RF write-port arbiter and zeroization sweep sequencer.
// Define RF_SCRUB_FAIR_EN for fair mode (core priority, bounded deferral); default is strict scrub priority.
module ibex_rf_scrub_ctrl #(
  parameter int RV32E     = 0,
  parameter int DataWidth = 32,
  parameter int MAX_DEFER = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 scrub_req_i,
  output logic                 scrub_busy_o,
  output logic                 scrub_done_o,
  input  logic                 wb_we_i,
  input  logic [4:0]           wb_waddr_i,
  input  logic [DataWidth-1:0] wb_wdata_i,
  output logic                 wb_stall_o,
  output logic                 rf_we_o,
  output logic [4:0]           rf_waddr_o,
  output logic [DataWidth-1:0] rf_wdata_o
);
  localparam int NUM_WORDS = RV32E ? 16 : 32;
  localparam logic [4:0] LAST = 5'(NUM_WORDS - 1);
  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;
  state_t     r_state, w_state_nxt;
  logic [4:0] r_ptr;
  logic       w_scrub, w_adv, w_last;
  assign w_last = r_ptr == LAST;
`ifdef RF_SCRUB_FAIR_EN
  localparam int DW = $clog2(MAX_DEFER + 1);
  logic [31:0]   r_skip;
  logic [DW-1:0] r_defer;
  logic          w_want, w_force;
  assign w_want  = !r_skip[r_ptr];
  assign w_force = r_defer == DW'(MAX_DEFER);
  assign w_scrub = r_state == SWEEP && w_want && (w_force || !wb_we_i);
  assign w_adv   = r_state == SWEEP && (w_scrub || !w_want);
  // Bitmap and deferral only live for the duration of one sweep.
  always_ff @(posedge clk_i) begin
    if (rst_i || r_state != SWEEP || (w_adv && w_last)) begin
      r_skip  <= '0;
      r_defer <= '0;
    end else begin
      if (wb_we_i && !wb_stall_o && wb_waddr_i != 5'd0) r_skip[wb_waddr_i] <= 1'b1;
      r_defer <= w_scrub ? '0 : (w_want && wb_we_i && !w_force) ? r_defer + 1'b1 : r_defer;
    end
  end
`else
  assign w_scrub = r_state == SWEEP;
  assign w_adv   = w_scrub;
`endif
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_ptr   <= 5'd1;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_adv ? (w_last ? 5'd1 : r_ptr + 5'd1) : r_ptr;
    end
  end
  always_comb begin
    w_state_nxt = r_state;
    w_state_nxt = r_state == IDLE  ? (scrub_req_i ? SWEEP : IDLE) :
                  r_state == SWEEP ? ((w_adv && w_last) ? DONE : SWEEP) : IDLE;
  end
  assign scrub_busy_o = r_state == SWEEP;
  assign scrub_done_o = r_state == DONE;
  assign wb_stall_o   = w_scrub && wb_we_i;
  assign rf_we_o      = w_scrub || wb_we_i;
  assign rf_waddr_o   = w_scrub ? r_ptr : wb_waddr_i;
  assign rf_wdata_o   = w_scrub ? '0 : wb_wdata_i;
endmodule

// File: tb/tb_ibex_rf_scrub_ctrl.sv
// tb_ibex_rf_scrub_ctrl: vector table, directed sweeps and randomized traffic against a queue-based model.
module tb_ibex_rf_scrub_ctrl;
  localparam int N    = 32;
  localparam int MAXD = 4;
`ifdef RF_SCRUB_FAIR_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif
  logic        clk = 1'b0;
  logic        rst, req, we;
  logic [4:0]  addr;
  logic [31:0] data;
  logic        busy, done, stall, rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  ibex_rf_scrub_ctrl #(.RV32E(0), .DataWidth(32), .MAX_DEFER(MAXD)) dut (
    .clk_i(clk), .rst_i(rst), .scrub_req_i(req), .scrub_busy_o(busy), .scrub_done_o(done),
    .wb_we_i(we), .wb_waddr_i(addr), .wb_wdata_i(data), .wb_stall_o(stall),
    .rf_we_o(rf_we), .rf_waddr_o(rf_waddr), .rf_wdata_o(rf_wdata)
  );
  always #5 clk = ~clk;
  int n_cmp = 0, n_err = 0;
  // model: phase 0 idle / 1 sweep / 2 done, queue of registers still to visit
  int          ph = 0, defer = 0;
  int          todo[$];
  bit          skipped[32];
  logic [31:0] mrf[32], srf[32];
  logic        o_we, o_stall, o_busy, o_done;
  logic [4:0]  o_a;
  logic [31:0] o_d;
  typedef struct {
    bit r, q, w; logic [4:0] a; logic [31:0] d;
    bit e_we; logic [4:0] e_a; logic [31:0] e_d; bit e_stall, e_busy, e_done;
  } vec_t;
  vec_t vt[4];
  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endfunction
  task automatic step(input bit r, input bit q, input bit w, input logic [4:0] a,
                      input logic [31:0] d, input bit c);
    bit scrub, pop, took, e_stall, e_we, acc;
    int head;
    logic [4:0] e_a;
    logic [31:0] e_d;
    rst = r; req = q; we = w; addr = a; data = d;
    #2;
    scrub = 0; pop = 0; took = 0; head = 0;
    if (ph == 1) begin
      head = todo[0];
      if (!FAIR) begin scrub = 1; pop = 1; end
      else if (skipped[head]) pop = 1;
      else if (defer == MAXD || !w) begin scrub = 1; pop = 1; end
      else took = 1;
    end
    e_stall = scrub && w;
    e_we    = scrub || w;
    e_a     = scrub ? 5'(head) : a;
    e_d     = scrub ? 32'd0 : d;
    o_we = rf_we; o_a = rf_waddr; o_d = rf_wdata; o_stall = stall; o_busy = busy; o_done = done;
    if (c) begin
      chk("rf_we", o_we, e_we);
      if (e_we) chk("rf_waddr", o_a, e_a);
      if (e_we) chk("rf_wdata", o_d, e_d);
      chk("stall", o_stall, e_stall);
      chk("busy", o_busy, ph == 1);
      chk("done", o_done, ph == 2);
    end
    @(posedge clk);
    if (o_we) srf[o_a] = o_d;
    if (e_we) mrf[e_a] = e_d;
    acc = ph == 1 && w && !e_stall && a != 5'd0;
    if (r) begin
      ph = 0; todo.delete(); defer = 0;
    end else if (ph == 0) begin
      if (q) begin
        ph = 1; todo.delete(); defer = 0;
        for (int i = 1; i < N; i++) todo.push_back(i);
        foreach (skipped[i]) skipped[i] = 0;
      end
    end else if (ph == 1) begin
      if (FAIR && acc) skipped[a] = 1;
      if (scrub) defer = 0;
      else if (took) defer++;
      if (pop) begin
        void'(todo.pop_front());
        if (todo.size() == 0) ph = 2;
      end
    end else ph = 0;
    #1;
  endtask
  task automatic prefill();
    for (int i = 1; i < N; i++) step(0, 0, 1, 5'(i), 32'hA5A50000 | i, 1);
  endtask
  task automatic quiet_check(input string nm, input int keep_reg, input logic [31:0] keep_val);
    int bad = 0;
    for (int i = 1; i < N; i++) if (srf[i] !== ((i == keep_reg) ? keep_val : 32'd0)) bad++;
    chk(nm, bad, 0);
  endtask
  initial begin
    int nb, nz, nd, ns;
    foreach (mrf[i]) begin mrf[i] = 32'h5A5A5A5A ^ i; srf[i] = mrf[i]; end
    vt[0] = '{1, 0, 1, 5'd5, 32'hDEADBEEF, 1, 5'd5, 32'hDEADBEEF, 0, 0, 0};
    vt[1] = '{0, 0, 1, 5'd5, 32'hDEADBEEF, 1, 5'd5, 32'hDEADBEEF, 0, 0, 0};
    vt[2] = '{0, 0, 0, 5'd9, 32'h00001234, 0, 5'd9, 32'h00001234, 0, 0, 0};
    vt[3] = '{0, 0, 1, 5'd0, 32'hFFFFFFFF, 1, 5'd0, 32'hFFFFFFFF, 0, 0, 0};
    #1;
    step(1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      step(vt[k].r, vt[k].q, vt[k].w, vt[k].a, vt[k].d, 1);
      chk("vec_we", o_we, vt[k].e_we);
      chk("vec_addr", o_a, vt[k].e_a);
      chk("vec_data", o_d, vt[k].e_d);
      chk("vec_flags", {o_stall, o_busy, o_done}, {vt[k].e_stall, vt[k].e_busy, vt[k].e_done});
    end
    // quiet sweep
    prefill();
    step(0, 1, 0, 0, 0, 1);
    nb = 0; nz = 0; nd = 0;
    for (int k = 0; k < 40; k++) begin
      step(0, k == 3, 0, 0, 0, 1);
      if (o_busy) nb++;
      if (o_busy && o_we && o_d == 0) nz++;
      if (o_done) nd++;
    end
    chk("quiet_busy_cycles", nb, N - 1);
    chk("quiet_zero_writes", nz, N - 1);
    chk("quiet_done_pulses", nd, 1);
    quiet_check("quiet_rf_zero", 0, 0);
    // core write held through a sweep
    prefill();
    step(0, 1, 0, 0, 0, 1);
    ns = 0;
    for (int k = 0; k < 200 && ph != 0; k++) begin
      step(0, 0, 1, 5'd7, 32'h77, 1);
      if (o_stall) ns++;
    end
    chk("held_stalls", ns, FAIR ? N - 2 : N - 1);
    chk("held_finished", ph, 0);
    quiet_check("held_survivor", 7, 32'h77);
`ifdef RF_SCRUB_FAIR_EN
    prefill();
    step(0, 1, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 1, 5'd20, 32'h1234, 1);
    chk("x20_not_stalled", o_stall, 0);
    for (int k = 0; k < 60 && ph != 0; k++) step(0, 0, 0, 0, 0, 1);
    quiet_check("x20_survivor", 20, 32'h1234);
`endif
    // reset in mid-sweep
    step(0, 1, 0, 0, 0, 1);
    for (int k = 0; k < 9; k++) step(0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 1);
    chk("rst_waddr_at_10", o_a, 10);
    step(0, 0, 0, 0, 0, 1);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    step(0, 1, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    chk("restart_addr", {o_we, o_a}, {1'b1, 5'd1});
    // randomized traffic
    for (int k = 0; k < 4000; k++)
      step($urandom_range(199) == 0, $urandom_range(9) == 0, 1'($urandom), 5'($urandom), $urandom, 1);
    begin
      int bad = 0;
      for (int i = 0; i < 32; i++) if (srf[i] !== mrf[i]) bad++;
      chk("random_rf_image", bad, 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
